// File: rtl/uart_probe_dump_if.sv
// Byte-stream handshake between the probe formatter and the UART transmitter/receiver.
interface uart_probe_dump_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid
    );
endinterface

// File: rtl/uart_probe_dump.sv
// Snapshots NUM_CH probe channels and prints one uppercase-hex ASCII line per snapshot,
// either periodically or on command, optionally restricted to channels that changed.
module uart_probe_dump #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CH_W   = 16,
    parameter int unsigned PERIOD = 13_500_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*CH_W-1:0]   probe,
    uart_probe_dump_if.master        bus
);
    localparam int unsigned ND    = CH_W / 4;
    localparam int unsigned TMR_W = $clog2(PERIOD);
    localparam int unsigned POS_W = 4;
    localparam int unsigned IDX_W = 4;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(2 + ND);
    localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_HDR, S_CH, S_EOL} state_t;

    state_t                   state;
    logic [TMR_W-1:0]         timer;
    logic                     paused, chg_only, base_valid, pending, frame_clr;
    logic [7:0]               frame;
    logic [NUM_CH*CH_W-1:0]   snap, prev;
    logic [NUM_CH-1:0]        mask;
    logic [IDX_W-1:0]         ch_idx;
    logic [POS_W-1:0]         pos;
    logic [7:0]               tx_data_q;
    logic                     tx_valid_q;

    logic                     tick_c, can_load_c, eol_done_c, skip_c, ch_done_c;
    logic                     cmd_pause_c, cmd_chg_c, cmd_dump_c, cmd_clr_c;
    logic [NUM_CH-1:0]        mask_c;
    logic [CH_W-1:0]          cur_ch_c;
    logic                     cur_mask_c;
    logic [3:0]               cur_nib_c;
    logic [7:0]               hdr_byte_c, ch_byte_c;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
    endfunction

    assign tick_c      = (timer == TMR_W'(PERIOD - 1));
    assign can_load_c  = !tx_valid_q || bus.tx_ready;
    assign cmd_pause_c = bus.rx_valid && (bus.rx_data == 8'h20);
    assign cmd_chg_c   = bus.rx_valid && (bus.rx_data == 8'h63);
    assign cmd_dump_c  = bus.rx_valid && (bus.rx_data == 8'h64);
    assign cmd_clr_c   = bus.rx_valid && (bus.rx_data == 8'h72);
    assign eol_done_c  = (state == S_EOL) && (pos == POS_W'(2)) && tx_valid_q && bus.tx_ready;
    assign skip_c      = chg_only && !cur_mask_c;
    assign ch_done_c   = skip_c || (can_load_c && (pos == LAST_POS));

    // Change mask against the previous snapshot, and the channel/nibble being printed
    always_comb begin
        mask_c     = '0;
        cur_ch_c   = '0;
        cur_mask_c = 1'b0;
        cur_nib_c  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            mask_c[i] = (probe[i*CH_W +: CH_W] != prev[i*CH_W +: CH_W]) || !base_valid;
            if (ch_idx == IDX_W'(i)) begin
                cur_ch_c   = snap[i*CH_W +: CH_W];
                cur_mask_c = mask[i];
            end
        end
        for (int unsigned j = 0; j < ND; j++) begin
            if (pos == POS_W'(3 + j)) cur_nib_c = cur_ch_c[(ND-1-j)*4 +: 4];
        end
    end

    always_comb begin
        hdr_byte_c = 8'h3A;
        if (pos == POS_W'(1)) hdr_byte_c = hex(frame[7:4]);
        else if (pos == POS_W'(2)) hdr_byte_c = hex(frame[3:0]);
        case (pos)
            POS_W'(0): ch_byte_c = 8'h20;
            POS_W'(1): ch_byte_c = hex(ch_idx);
            POS_W'(2): ch_byte_c = 8'h3D;
            default:   ch_byte_c = hex(cur_nib_c);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            paused     <= 1'b0;
            chg_only   <= 1'b0;
            base_valid <= 1'b0;
            pending    <= 1'b0;
            frame_clr  <= 1'b0;
            frame      <= '0;
            snap       <= '0;
            prev       <= '0;
            mask       <= '0;
            ch_idx     <= '0;
            pos        <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            timer <= tick_c ? '0 : timer + TMR_W'(1);
            if (tx_valid_q && bus.tx_ready) tx_valid_q <= 1'b0;
            if (cmd_pause_c) paused <= !paused;
            if (cmd_chg_c) chg_only <= !chg_only;
            if (cmd_dump_c) pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    // A tick outside IDLE is simply lost; one seen here starts a capture directly
                    if (pending || cmd_dump_c || (tick_c && !paused)) begin
                        pending <= 1'b0;
                        state   <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    snap       <= probe;
                    prev       <= probe;
                    mask       <= mask_c;
                    base_valid <= 1'b1;
                    if (chg_only && (mask_c == '0)) begin
                        state <= S_IDLE;
                    end else begin
                        tx_data_q  <= 8'h46;
                        tx_valid_q <= 1'b1;
                        pos        <= POS_W'(1);
                        state      <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (can_load_c) begin
                        tx_data_q  <= hdr_byte_c;
                        tx_valid_q <= 1'b1;
                        if (pos == POS_W'(3)) begin
                            pos    <= '0;
                            ch_idx <= '0;
                            state  <= S_CH;
                        end else begin
                            pos <= pos + POS_W'(1);
                        end
                    end
                end
                S_CH: begin
                    if (!skip_c && can_load_c) begin
                        tx_data_q  <= ch_byte_c;
                        tx_valid_q <= 1'b1;
                        pos        <= pos + POS_W'(1);
                    end
                    if (ch_done_c) begin
                        pos <= '0;
                        if (ch_idx == LAST_CH) state <= S_EOL;
                        else ch_idx <= ch_idx + IDX_W'(1);
                    end
                end
                S_EOL: begin
                    if (pos == POS_W'(2)) begin
                        if (eol_done_c) begin
                            frame     <= (frame_clr || cmd_clr_c) ? 8'h00 : frame + 8'd1;
                            frame_clr <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end else if (can_load_c) begin
                        tx_data_q  <= (pos == POS_W'(0)) ? 8'h0D : 8'h0A;
                        tx_valid_q <= 1'b1;
                        pos        <= pos + POS_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A clear during a line leaves its header alone and wins over the LF increment
            if (cmd_clr_c) begin
                base_valid <= 1'b0;
                if (state == S_IDLE || state == S_CAPTURE) frame <= 8'h00;
                else if (!eol_done_c) frame_clr <= 1'b1;
            end
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
endmodule

// File: tb/tb_uart_probe_dump.sv
// Directed bench for uart_probe_dump: per-period windows of expected line text plus reset sequences.
module tb_uart_probe_dump;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned PERIOD = 200;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] probe;
        bit          rnd;
        int          r_after;
        string       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] probe;

    uart_probe_dump_if bus();

    uart_probe_dump #(.NUM_CH(NUM_CH), .CH_W(CH_W), .PERIOD(PERIOD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .probe (probe),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    string rcv = "";
    int    viol = 0;
    logic  hold_q = 1'b0;
    logic [7:0] hold_d = 8'h00;
    int    n_chk = 0;
    int    n_pass = 0;
    vec_t  tbl[$];

    // Receiver model and hold-stability watcher
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q && (!bus.tx_valid || bus.tx_data != hold_d)) viol++;
            if (bus.tx_valid && bus.tx_ready) rcv = $sformatf("%s%c", rcv, bus.tx_data);
            hold_q = bus.tx_valid && !bus.tx_ready;
            hold_d = bus.tx_data;
        end
    end

    function automatic string vis(string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            c = s.getc(i);
            if (c == 8'h0D) r = {r, "\\r"};
            else if (c == 8'h0A) r = {r, "\\n"};
            else r = $sformatf("%s%c", r, c);
        end
        return r;
    endfunction

    function automatic vec_t mk(logic [7:0] c, logic [15:0] p, bit rnd, int ra, string e);
        vec_t v;
        v.cmd = c; v.probe = p; v.rnd = rnd; v.r_after = ra; v.exp = e;
        return v;
    endfunction

    task automatic chk_str(string name, string got, string exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got \"%s\" expected \"%s\"", name, vis(got), vis(exp));
    endtask

    task automatic chk_int(string name, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // One snapshot period starting mid-period, so exactly one tick falls inside it
    task automatic run_window(vec_t v, string name);
        bit r_sent = 1'b0;
        rcv = "";
        probe = v.probe;
        bus.tx_ready = 1'b1;
        if (v.cmd != 8'h00) begin
            bus.rx_data  = v.cmd;
            bus.rx_valid = 1'b1;
        end
        for (int c = 0; c < int'(PERIOD); c++) begin
            @(posedge clk); #1;
            bus.rx_valid = 1'b0;
            bus.tx_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v.r_after > 0 && !r_sent && rcv.len() >= v.r_after) begin
                bus.rx_data  = 8'h72;
                bus.rx_valid = 1'b1;
                r_sent = 1'b1;
            end
        end
        chk_str(name, rcv, v.exp);
    endtask

    task automatic start_after_reset(string exp_first, string tag);
        int lat = 0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_int({tag, "_rst_tx_valid"}, int'(bus.tx_valid), 0);
        chk_int({tag, "_rst_tx_data"}, int'(bus.tx_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rcv = "";
        for (int i = 1; i <= 2 * int'(PERIOD); i++) begin
            @(negedge clk);
            if (bus.tx_valid) begin
                lat = i;
                break;
            end
        end
        chk_int({tag, "_first_valid_cycle"}, lat, int'(PERIOD) + 1);
        repeat (100) @(posedge clk);
        #1;
        chk_str({tag, "_first_line"}, rcv, exp_first);
        rcv = "";
    endtask

    initial begin
        bit seen;
        probe        = 16'hA53C;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;

        start_after_reset("F00: 0=3C 1=A5\r\n", "boot");

        tbl.push_back(mk(8'h00, 16'hA53C, 1'b0, 0, "F01: 0=3C 1=A5\r\n"));
        tbl.push_back(mk(8'h20, 16'hA53C, 1'b0, 0, ""));
        tbl.push_back(mk(8'h00, 16'hA53C, 1'b0, 0, ""));
        tbl.push_back(mk(8'h00, 16'hA53C, 1'b0, 0, ""));
        tbl.push_back(mk(8'h64, 16'hA53C, 1'b0, 0, "F02: 0=3C 1=A5\r\n"));
        tbl.push_back(mk(8'h20, 16'hA53C, 1'b0, 0, "F03: 0=3C 1=A5\r\n"));
        tbl.push_back(mk(8'h63, 16'h5A3C, 1'b0, 0, "F04: 1=5A\r\n"));
        tbl.push_back(mk(8'h00, 16'h5A3C, 1'b0, 0, ""));
        tbl.push_back(mk(8'h00, 16'h5A3C, 1'b0, 0, ""));
        tbl.push_back(mk(8'h00, 16'h5A3C, 1'b0, 0, ""));
        tbl.push_back(mk(8'h00, 16'h5A77, 1'b0, 0, "F05: 0=77\r\n"));
        tbl.push_back(mk(8'h63, 16'h5A77, 1'b0, 0, "F06: 0=77 1=5A\r\n"));
        tbl.push_back(mk(8'h00, 16'h1234, 1'b1, 0, "F07: 0=34 1=12\r\n"));
        tbl.push_back(mk(8'h00, 16'hBEEF, 1'b1, 0, "F08: 0=EF 1=BE\r\n"));
        tbl.push_back(mk(8'h63, 16'hBEEF, 1'b0, 0, ""));
        tbl.push_back(mk(8'h00, 16'hBE00, 1'b0, 3, "F09: 0=00\r\n"));
        tbl.push_back(mk(8'h00, 16'hBE00, 1'b0, 0, "F00: 0=00 1=BE\r\n"));
        tbl.push_back(mk(8'h00, 16'hBE00, 1'b0, 0, ""));

        foreach (tbl[i]) run_window(tbl[i], $sformatf("window%0d", i));

        // Reset in the middle of a line must drop tx_valid without waiting for a clock
        probe = 16'hC0DE;
        seen = 1'b0;
        for (int i = 0; i < 2 * int'(PERIOD) && !seen; i++) begin
            @(negedge clk);
            seen = bus.tx_valid;
        end
        chk_int("midline_started", int'(seen), 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_int("async_tx_valid_drop", int'(bus.tx_valid), 0);

        start_after_reset("F00: 0=DE 1=C0\r\n", "rerun");
        run_window(mk(8'h00, 16'hC0DE, 1'b0, 0, "F01: 0=DE 1=C0\r\n"), "post_reset_all_mode");

        chk_int("tx_hold_stable", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
